// File: rtl/digit_serial_mult_pkg.sv
`default_nettype none
// ============================================================================
// Package : mult_pkg
// Purpose : Shared types and constants for the digit-serial multiplier.
//           It provides the sequencer state encoding, the digit and
//           partial-product widths, and helpers that size the digit
//           counters from the operand width.
// Revision: 1.0  initial release
// ============================================================================
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 2;  // bits per operand digit
  localparam int PP_W    = 4;  // bits in one digit x digit product

  // Number of 2-bit digits in a WIDTH-bit operand.
  function automatic int digit_count(input int width);
    return width / DIGIT_W;
  endfunction

  // Digit index counter width.  It is at least one bit, so that N=1 still
  // has a legal counter.
  function automatic int index_width(input int width);
    int n;
    n = digit_count(width);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_serial_mult_if.sv
`default_nettype none
// ============================================================================
// Interface : digit_serial_mult_if
// Purpose   : Operand and result handshake bundle for digit_serial_mult.
// Signals   : in_valid/in_ready/a/b  - operand channel (producer -> block)
//             out_valid/out_ready/product - result channel (block -> consumer)
//             busy                   - block is in RUN or DONE
// Modports  : master - the producer/consumer side (drives operands, ready)
//             slave  - the multiplier
// Revision  : 1.0  initial release
// ============================================================================
interface digit_serial_mult_if #(
  parameter int WIDTH = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface
`default_nettype wire

// File: rtl/digit_serial_mult_mul2x2_cell.sv
`default_nettype none
// ============================================================================
// Module  : mul2x2_cell
// Purpose : Purely combinational 2-bit x 2-bit unsigned product cell.
// Ports   : x [1:0] - first digit
//           y [1:0] - second digit
//           p [3:0] - x*y (max 9, fits in 4 bits)
// Revision: 1.0  initial release
// ============================================================================
module mul2x2_cell
  import mult_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  output logic [PP_W-1:0]    p
);

  // Both operands are widened before the multiply, so the full 4-bit result
  // is kept.
  assign p = PP_W'(x) * PP_W'(y);

endmodule
`default_nettype wire

// File: rtl/digit_serial_mult.sv
`default_nettype none
// ============================================================================
// Module  : digit_serial_mult
// Purpose : Sequential WIDTH x WIDTH unsigned multiplier.  Each operand is
//           split into N = WIDTH/2 two-bit digits.  One digit pair per cycle
//           goes through mul2x2_cell.  Each 4-bit partial product is shifted
//           by 2*(i+j) and accumulated into a 2*WIDTH accumulator.  Latency is
//           N*N cycles from accept to out_valid, and it does not depend on
//           the operand values.
// Ports   : clk - rising-edge clock
//           rst - synchronous active-high reset
//           bus - digit_serial_mult_if.slave (in_valid/in_ready/a/b,
//                 out_valid/out_ready/product, busy)
// Notes   : WIDTH must be even and >= 2, and it must match the WIDTH of the
//           connected interface.
// Revision: 1.0  initial release
// ============================================================================
module digit_serial_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  digit_serial_mult_if.slave    bus
);

  localparam int N     = digit_count(WIDTH);
  localparam int IDX_W = index_width(WIDTH);
  localparam int PW    = 2 * WIDTH;
  localparam int SH_W  = $clog2(PW) + 1;  // holds shifts up to 2*WIDTH-4
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t               state;
  state_t               state_next;

  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [PW-1:0]        acc;
  logic [PW-1:0]        product_reg;
  logic [IDX_W-1:0]     i_idx;
  logic [IDX_W-1:0]     j_idx;

  logic [DIGIT_W-1:0]   a_dig;
  logic [DIGIT_W-1:0]   b_dig;
  logic [PP_W-1:0]      pp;
  logic [PP_W-1:0]      pp_cell;
  logic [PW-1:0]        pp_ext;
  logic [PW-1:0]        acc_sum;
  logic [SH_W-1:0]      shamt;
  logic                 accept;
  logic                 last_step;

  // --------------------------------------------------------------------------
  // Digit selection and the product cell
  // --------------------------------------------------------------------------
  assign a_dig = a_reg[DIGIT_W*i_idx +: DIGIT_W];
  assign b_dig = b_reg[DIGIT_W*j_idx +: DIGIT_W];

  mul2x2_cell u_cell (
    .x (a_dig),
    .y (b_dig),
    .p (pp_cell)
  );

  assign pp = pp_cell;

  // Digit (i,j) has weight 4^(i+j), so the shift is 2*(i+j) bit positions.
  assign shamt = (SH_W'(i_idx) + SH_W'(j_idx)) << 1;

  always_comb begin
    pp_ext           = '0;
    pp_ext[PP_W-1:0] = pp;
  end

  assign acc_sum = acc + (pp_ext << shamt);

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_step = (state == RUN) && (i_idx == LAST) && (j_idx == LAST);

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last_step)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand capture, digit counters and accumulator
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      product_reg <= '0;
      i_idx       <= '0;
      j_idx       <= '0;
    end else begin
      if (accept) begin
        a_reg <= bus.a;
        b_reg <= bus.b;
        acc   <= '0;
        i_idx <= '0;
        j_idx <= '0;
      end else if (state == RUN) begin
        acc <= acc_sum;
        // j is the inner loop.  i advances when j wraps.  After the last
        // pair both indices return to 0.
        if (j_idx == LAST) begin
          j_idx <= '0;
          i_idx <= (i_idx == LAST) ? '0 : i_idx + IDX_W'(1);
        end else begin
          j_idx <= j_idx + IDX_W'(1);
        end
        // The result is captured on the same edge that enters DONE.  It then
        // holds until the next operation completes, or until reset.
        if (last_step) begin
          product_reg <= acc_sum;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state
  // --------------------------------------------------------------------------
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.product   = product_reg;

endmodule
`default_nettype wire
